regfile_sb: RTL and testbench
=============================

Name: regfile_sb

Overview:
- Parametrised successor to the 16x16 register file.
- Generic width and depth, two combinational read ports, one write port.
- Adds write-to-read bypass, optional hard-wired zero register, and a per-register pending-write scoreboard.
- Sits between decode and writeback. Decode reserves destinations and reads Busy flags to stall on RAW hazards; writeback writes results and clears reservations.

Parameters:
- DATA_W, 16, data word width in bits.
- ADDR_W, 4, register index width; depth NREG = 2**ADDR_W.
- ZERO_REG, 0, when 1 register 0 always reads 0, ignores writes, and is never marked busy.
- BYPASS, 1, when 1 a same-cycle write is forwarded to matching read ports.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- SrcReg1  in  ADDR_W  read port 1 index.
- SrcReg2  in  ADDR_W  read port 2 index.
- SrcData1  out  DATA_W  read port 1 data (plain output, no tri-state).
- SrcData2  out  DATA_W  read port 2 data.
- DstReg  in  ADDR_W  write index.
- WriteReg  in  1  write enable; also clears the scoreboard bit of DstReg.
- DstData  in  DATA_W  write data.
- ReserveEn  in  1  mark ReserveReg as pending-write.
- ReserveReg  in  ADDR_W  index to reserve.
- Busy1  out  1  SrcReg1 has an outstanding reservation not satisfied this cycle.
- Busy2  out  1  same for SrcReg2.
- ResvConflict  out  1  registered; reservation was attempted on an already-busy register.
- BusyCount  out  ADDR_W+1  registered; number of busy registers.

Behaviour:

Reset
- rst low asynchronously clears all NREG registers to 0, all busy bits, ResvConflict and BusyCount.
- Reset mid-operation discards all pending reservations.
- First rising edge after rst deasserts performs normal operation.

Write
- On rising clk with WriteReg=1: reg[DstReg] <= DstData and busy[DstReg] <= 0.
- Exception: when ZERO_REG=1 and DstReg=0, the write is dropped.
- The write is visible on the read ports one cycle later without bypass.

Read
- Combinational, zero latency: SrcDataN = reg[SrcRegN].
- Bypass: when BYPASS=1, WriteReg=1, DstReg==SrcRegN and the write is not dropped, SrcDataN = DstData in the same cycle.
- Both ports may bypass simultaneously.
- When ZERO_REG=1 and SrcRegN=0, SrcDataN = 0 regardless of bypass.

Scoreboard
- busy[NREG] vector, updated on the rising edge.
- ReserveEn=1 sets busy[ReserveReg]; ignored for reg 0 when ZERO_REG=1.
- Simultaneous WriteReg and ReserveEn to the same index leaves the bit set: the new reservation wins and the old result is consumed.
- Simultaneous events to different indices are applied independently.
- WriteReg to a non-busy register is legal and leaves it clear.

Busy outputs
- Combinational: BusyN = busy[SrcRegN] & ~(BYPASS & WriteReg & DstReg==SrcRegN).
- When BYPASS=0 the raw bit is reported.
- BusyN is always 0 for reg 0 when ZERO_REG=1.

ResvConflict
- Next-cycle pulse (one cycle) when ReserveEn=1 and busy[ReserveReg]=1 before the edge, and the reservation is not cleared by a same-cycle WriteReg to that index.
- The reservation still takes effect (bit stays set).

BusyCount
- Registered population count of the busy vector after each edge.
- Range 0..NREG (NREG-1 when ZERO_REG=1); never wraps.

Test Plan:
- Reset/zero: write 0x1234 to every register, assert rst low between edges -> all reads 0x0000, BusyCount=0, ResvConflict=0 immediately (asynchronous).
- Write then read: write R5=0xBEEF, next cycle SrcReg1=5, SrcReg2=5 -> both read 0xBEEF. Same-cycle read of R6 while writing R6=0x00A5 with BYPASS=1 -> SrcData=0x00A5; with BYPASS=0 -> old value.
- ZERO_REG=1: write R0=0xFFFF -> SrcData1 at index 0 reads 0. Reserve R0 -> Busy1=0, BusyCount unchanged.
- Scoreboard: reserve R3 -> Busy1(Src=3)=1, BusyCount=1. Writeback R3=0x0042 -> same-cycle Busy1=0 and SrcData1=0x0042; next cycle BusyCount=0.
- Conflict: reserve R7 twice on consecutive cycles without writeback -> ResvConflict=1 for exactly one cycle, BusyCount=1. Reserve R7 and write R7 in the same cycle -> bit stays 1, no conflict pulse.
- Full occupancy: ADDR_W=4, ZERO_REG=0, reserve all 16 registers -> BusyCount=16; write all back -> BusyCount=0.

Source files
------------

// File: rtl/regfile_sb.sv
// Parametrised register file with write-to-read bypass, optional hard-wired
// zero register and a per-register pending-write scoreboard. Decode reserves
// destinations and stalls on Busy; writeback writes results and clears them.
module regfile_sb #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 4,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] SrcReg1,
  input  logic [ADDR_W-1:0] SrcReg2,
  output logic [DATA_W-1:0] SrcData1,
  output logic [DATA_W-1:0] SrcData2,
  input  logic [ADDR_W-1:0] DstReg,
  input  logic              WriteReg,
  input  logic [DATA_W-1:0] DstData,
  input  logic              ReserveEn,
  input  logic [ADDR_W-1:0] ReserveReg,
  output logic              Busy1,
  output logic              Busy2,
  output logic              ResvConflict,
  output logic [ADDR_W:0]   BusyCount
);

  localparam int unsigned NREG  = 2**ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam bit          ZR    = (ZERO_REG != 0);
  localparam bit          BP    = (BYPASS != 0);

  logic [DATA_W-1:0] regs_q [NREG];
  logic [NREG-1:0]   busy_q, busy_d;
  logic              conflict_q, conflict_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic wr_ok, rsv_ok;
  logic src1_zero, src2_zero;
  logic hit1, hit2;

  // Qualify write/reserve: register 0 is inert when hard-wired to zero.
  always_comb begin
    wr_ok     = WriteReg  & ~(ZR & (DstReg == '0));
    rsv_ok    = ReserveEn & ~(ZR & (ReserveReg == '0));
    src1_zero = ZR & (SrcReg1 == '0);
    src2_zero = ZR & (SrcReg2 == '0);
    hit1      = (DstReg == SrcReg1);
    hit2      = (DstReg == SrcReg2);
  end

  // Scoreboard next state: writeback clears first, reservation then sets,
  // so a same-index reserve+write leaves the bit set.
  always_comb begin
    busy_d = busy_q;
    if (wr_ok)  busy_d[DstReg]     = 1'b0;
    if (rsv_ok) busy_d[ReserveReg] = 1'b1;
    conflict_d = rsv_ok & busy_q[ReserveReg] & ~(wr_ok & (DstReg == ReserveReg));
    count_d = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      count_d = count_d + CNT_W'(busy_d[i]);
    end
  end

  // Register array storage with asynchronous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_ok) begin
      regs_q[DstReg] <= DstData;
    end
  end

  // Scoreboard, conflict pulse and occupancy count state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q     <= '0;
      conflict_q <= 1'b0;
      count_q    <= '0;
    end else begin
      busy_q     <= busy_d;
      conflict_q <= conflict_d;
      count_q    <= count_d;
    end
  end

  // Combinational read ports with zero-register override and bypass.
  always_comb begin
    if (src1_zero)           SrcData1 = '0;
    else if (BP & wr_ok & hit1) SrcData1 = DstData;
    else                     SrcData1 = regs_q[SrcReg1];

    if (src2_zero)           SrcData2 = '0;
    else if (BP & wr_ok & hit2) SrcData2 = DstData;
    else                     SrcData2 = regs_q[SrcReg2];
  end

  // Busy flags drop in the cycle the pending result is being forwarded.
  always_comb begin
    Busy1        = busy_q[SrcReg1] & ~(BP & WriteReg & hit1) & ~src1_zero;
    Busy2        = busy_q[SrcReg2] & ~(BP & WriteReg & hit2) & ~src2_zero;
    ResvConflict = conflict_q;
    BusyCount    = count_q;
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: instance a uses defaults (bypass, no zero
// register), instance b has ZERO_REG=1, BYPASS=0. Both share the inputs.
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  SrcReg1, SrcReg2, DstReg, ReserveReg;
  logic        WriteReg, ReserveEn;
  logic [15:0] DstData;

  logic [15:0] a_d1, a_d2, b_d1, b_d2;
  logic        a_b1, a_b2, b_b1, b_b2, a_cf, b_cf;
  logic [4:0]  a_cnt, b_cnt;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  regfile_sb u_a (
    .clk(clk), .rst(rst), .SrcReg1(SrcReg1), .SrcReg2(SrcReg2),
    .SrcData1(a_d1), .SrcData2(a_d2), .DstReg(DstReg), .WriteReg(WriteReg),
    .DstData(DstData), .ReserveEn(ReserveEn), .ReserveReg(ReserveReg),
    .Busy1(a_b1), .Busy2(a_b2), .ResvConflict(a_cf), .BusyCount(a_cnt)
  );

  regfile_sb #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(1), .BYPASS(0)) u_b (
    .clk(clk), .rst(rst), .SrcReg1(SrcReg1), .SrcReg2(SrcReg2),
    .SrcData1(b_d1), .SrcData2(b_d2), .DstReg(DstReg), .WriteReg(WriteReg),
    .DstData(DstData), .ReserveEn(ReserveEn), .ReserveReg(ReserveReg),
    .Busy1(b_b1), .Busy2(b_b2), .ResvConflict(b_cf), .BusyCount(b_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    SrcReg1 = '0; SrcReg2 = '0; DstReg = '0; ReserveReg = '0;
    WriteReg = 1'b0; ReserveEn = 1'b0; DstData = '0;
    #2;
    check("rst_cnt_a", a_cnt, 0);
    check("rst_cf_a",  a_cf, 0);
    check("rst_rd_a",  a_d1, 0);
    #10 rst = 1'b1;

    // Fill every register with 0x1234.
    for (int i = 0; i < 16; i++) begin
      WriteReg = 1'b1; DstReg = 4'(i); DstData = 16'h1234;
      tick();
    end
    WriteReg = 1'b0;
    SrcReg1 = 4'd5; SrcReg2 = 4'd0; #1;
    check("fill_a_r5", a_d1, 16'h1234);
    check("fill_a_r0", a_d2, 16'h1234);
    check("fill_b_r5", b_d1, 16'h1234);
    check("fill_b_r0", b_d2, 16'h0000);

    // Reserve R2 twice to get a non-zero count and a conflict pulse.
    ReserveEn = 1'b1; ReserveReg = 4'd2;
    tick();
    check("r2_cnt_a", a_cnt, 1);
    check("r2_cf_a",  a_cf, 0);
    tick();
    ReserveEn = 1'b0;
    check("r2_cf2_a", a_cf, 1);
    check("r2_cf2_b", b_cf, 1);

    // Asynchronous reset mid-cycle.
    rst = 1'b0; #1;
    SrcReg1 = 4'd5; SrcReg2 = 4'd2; #1;
    check("arst_cf_a",  a_cf, 0);
    check("arst_cnt_a", a_cnt, 0);
    check("arst_cnt_b", b_cnt, 0);
    check("arst_rd_a",  a_d1, 0);
    check("arst_rd_b",  b_d1, 0);
    check("arst_busy_a", a_b2, 0);
    #2 rst = 1'b1;

    // Write R5=BEEF: bypass on a, old value on b, then both see it.
    WriteReg = 1'b1; DstReg = 4'd5; DstData = 16'hBEEF;
    SrcReg1 = 4'd5; SrcReg2 = 4'd5; #1;
    check("byp_a_r5", a_d1, 16'hBEEF);
    check("nobyp_b_r5", b_d1, 16'h0000);
    tick();
    WriteReg = 1'b0; #1;
    check("rd_a_p1", a_d1, 16'hBEEF);
    check("rd_a_p2", a_d2, 16'hBEEF);
    check("rd_b_p1", b_d1, 16'hBEEF);
    check("rd_b_p2", b_d2, 16'hBEEF);

    // Same-cycle R6 read on both ports.
    WriteReg = 1'b1; DstReg = 4'd6; DstData = 16'h00A5;
    SrcReg1 = 4'd6; SrcReg2 = 4'd6; #1;
    check("byp_a_r6_p1", a_d1, 16'h00A5);
    check("byp_a_r6_p2", a_d2, 16'h00A5);
    check("nobyp_b_r6", b_d2, 16'h0000);
    tick();
    WriteReg = 1'b0;

    // Register 0: writable on a, hard-wired zero on b.
    WriteReg = 1'b1; DstReg = 4'd0; DstData = 16'hFFFF; SrcReg1 = 4'd0; #1;
    check("r0_byp_a", a_d1, 16'hFFFF);
    check("r0_wr_b",  b_d1, 16'h0000);
    tick();
    WriteReg = 1'b0; #1;
    check("r0_rd_a", a_d1, 16'hFFFF);
    check("r0_rd_b", b_d1, 16'h0000);
    ReserveEn = 1'b1; ReserveReg = 4'd0;
    tick();
    ReserveEn = 1'b0; #1;
    check("r0_busy_a", a_b1, 1);
    check("r0_cnt_a",  a_cnt, 1);
    check("r0_busy_b", b_b1, 0);
    check("r0_cnt_b",  b_cnt, 0);
    WriteReg = 1'b1; DstReg = 4'd0; DstData = 16'h0000; #1;
    check("r0_wb_busy_a", a_b1, 0);
    tick();
    WriteReg = 1'b0; #1;
    check("r0_wb_cnt_a", a_cnt, 0);

    // Scoreboard on R3.
    ReserveEn = 1'b1; ReserveReg = 4'd3;
    tick();
    ReserveEn = 1'b0; SrcReg1 = 4'd3; #1;
    check("r3_busy_a", a_b1, 1);
    check("r3_busy_b", b_b1, 1);
    check("r3_cnt_a",  a_cnt, 1);
    check("r3_cnt_b",  b_cnt, 1);
    WriteReg = 1'b1; DstReg = 4'd3; DstData = 16'h0042; #1;
    check("r3_wb_busy_a", a_b1, 0);
    check("r3_wb_data_a", a_d1, 16'h0042);
    check("r3_wb_busy_b", b_b1, 1);
    check("r3_wb_data_b", b_d1, 16'h0000);
    tick();
    WriteReg = 1'b0; #1;
    check("r3_cnt0_a", a_cnt, 0);
    check("r3_cnt0_b", b_cnt, 0);
    check("r3_data_b", b_d1, 16'h0042);
    check("r3_busy0_b", b_b1, 0);

    // Conflict on R7: double reserve pulses once.
    ReserveEn = 1'b1; ReserveReg = 4'd7;
    tick();
    check("r7_cf_first", a_cf, 0);
    tick();
    ReserveEn = 1'b0;
    check("r7_cf_pulse", a_cf, 1);
    check("r7_cnt",      a_cnt, 1);
    tick();
    check("r7_cf_gone", a_cf, 0);
    // Reserve and write R7 together: bit stays, no pulse.
    ReserveEn = 1'b1; ReserveReg = 4'd7;
    WriteReg = 1'b1; DstReg = 4'd7; DstData = 16'h7777;
    tick();
    ReserveEn = 1'b0; WriteReg = 1'b0; SrcReg1 = 4'd7; #1;
    check("r7_rw_cf",   a_cf, 0);
    check("r7_rw_busy", a_b1, 1);
    check("r7_rw_cnt",  b_cnt, 1);
    check("r7_rw_data", a_d1, 16'h7777);
    // Independent events: write R7 while reserving R9.
    WriteReg = 1'b1; DstReg = 4'd7; ReserveEn = 1'b1; ReserveReg = 4'd9;
    tick();
    WriteReg = 1'b0; ReserveEn = 1'b0;
    SrcReg1 = 4'd7; SrcReg2 = 4'd9; #1;
    check("ind_busy7", a_b1, 0);
    check("ind_busy9", a_b2, 1);
    check("ind_cnt",   a_cnt, 1);
    WriteReg = 1'b1; DstReg = 4'd9;
    tick();
    WriteReg = 1'b0;

    // Full occupancy.
    for (int i = 0; i < 16; i++) begin
      ReserveEn = 1'b1; ReserveReg = 4'(i);
      tick();
    end
    ReserveEn = 1'b0; SrcReg1 = 4'd0; SrcReg2 = 4'd15; #1;
    check("full_cnt_a", a_cnt, 16);
    check("full_cnt_b", b_cnt, 15);
    check("full_b0_a",  a_b1, 1);
    check("full_b0_b",  b_b1, 0);
    check("full_b15_b", b_b2, 1);
    for (int i = 0; i < 16; i++) begin
      WriteReg = 1'b1; DstReg = 4'(i); DstData = 16'(i);
      tick();
    end
    WriteReg = 1'b0; #1;
    check("empty_cnt_a", a_cnt, 0);
    check("empty_cnt_b", b_cnt, 0);
    check("empty_rd15",  a_d2, 16'h000F);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
